// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback queue: data width, register
// address width and the retire-queue entry layout.
package rf_wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic              ready;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy vector: a register is busy while any valid queued entry
// targets it. x0 is never busy.
module rf_scoreboard
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  output logic      [31:0]      busy
);

  // ready/data are part of the entry but irrelevant to hazard tracking
  logic unused_bits;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    busy        = '0;
    unused_bits = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].valid) busy[entries[i].rd] = 1'b1;
      unused_bits = unused_bits ^ (^{entries[i].ready, entries[i].data});
    end
    busy[0] = 1'b0;
  end

endmodule

// File: rtl/rf_writeback_queue.sv
// In-order retire queue driving the single regfile write port. ALU results
// enter ready; load results are filled later by slot tag.
module rf_writeback_queue
  import rf_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int TW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [REG_AW-1:0] alloc_rd,
  input  logic              alloc_is_load,
  input  logic [XLEN-1:0]   alloc_data,
  output logic [TW-1:0]     alloc_tag,
  input  logic              ld_valid,
  input  logic [TW-1:0]     ld_tag,
  input  logic [XLEN-1:0]   ld_data,
  output logic              wreg,
  output logic [REG_AW-1:0] waddr,
  output logic [XLEN-1:0]   wrdata,
  output logic [31:0]       busy,
  output logic              ld_err
);

  localparam logic [TW:0] FULL_CNT = DEPTH[TW:0];

  logic [TW-1:0]     head, tail;
  logic [TW:0]       count;
  logic [DEPTH-1:0]  e_valid, e_ready;
  logic [REG_AW-1:0] e_rd   [DEPTH];
  logic [XLEN-1:0]   e_data [DEPTH];

  logic full, do_alloc, fill_ok, do_fill, do_retire;

  assign full        = (count == FULL_CNT);
  assign alloc_ready = !full && !flush && rst_n;
  assign alloc_tag   = tail;
  assign do_alloc    = alloc_valid && alloc_ready;
  // A fill is legal only for a queued load still waiting on its data.
  assign fill_ok     = e_valid[ld_tag] && !e_ready[ld_tag];
  assign do_fill     = ld_valid && !flush && fill_ok;
  assign do_retire   = e_valid[head] && e_ready[head] && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      e_valid <= '0;
      e_ready <= '0;
      wreg    <= 1'b0;
      waddr   <= '0;
      wrdata  <= '0;
      ld_err  <= 1'b0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      e_valid <= '0;
      e_ready <= '0;
      wreg    <= 1'b0;
      ld_err  <= 1'b0;
    end else begin
      ld_err <= ld_valid && !fill_ok;
      if (do_fill) e_ready[ld_tag] <= 1'b1;

      if (do_retire) begin
        e_valid[head] <= 1'b0;
        head          <= head + 1'b1;
        wreg          <= (e_rd[head] != '0);
        waddr         <= e_rd[head];
        wrdata        <= e_data[head];
      end else begin
        wreg <= 1'b0;
      end

      // Alloc and retire never share a slot: equal pointers mean full (alloc
      // blocked) or empty (nothing to retire).
      if (do_alloc) begin
        e_valid[tail] <= 1'b1;
        e_ready[tail] <= !alloc_is_load;
        tail          <= tail + 1'b1;
      end

      count <= count + {{TW{1'b0}}, do_alloc} - {{TW{1'b0}}, do_retire};
    end
  end

  // NOTE: payload storage is deliberately not reset; e_valid gates every use.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      e_rd[tail]   <= alloc_rd;
      e_data[tail] <= alloc_data;
    end
    if (do_fill) e_data[ld_tag] <= ld_data;
  end

  wb_entry_t [DEPTH-1:0] entries;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = '{valid: e_valid[i], ready: e_ready[i], rd: e_rd[i], data: e_data[i]};
    end
  end

  rf_scoreboard #(.DEPTH(DEPTH)) u_scoreboard (
    .entries (entries),
    .busy    (busy)
  );

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue (DEPTH=4): inputs change and outputs
// are sampled 1ns after each rising edge.
module tb_rf_writeback_queue;
  import rf_wb_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              alloc_valid;
  logic              alloc_ready;
  logic [REG_AW-1:0] alloc_rd;
  logic              alloc_is_load;
  logic [XLEN-1:0]   alloc_data;
  logic [1:0]        alloc_tag;
  logic              ld_valid;
  logic [1:0]        ld_tag;
  logic [XLEN-1:0]   ld_data;
  logic              wreg;
  logic [REG_AW-1:0] waddr;
  logic [XLEN-1:0]   wrdata;
  logic [31:0]       busy;
  logic              ld_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rf_writeback_queue #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_rd      (alloc_rd),
    .alloc_is_load (alloc_is_load),
    .alloc_data    (alloc_data),
    .alloc_tag     (alloc_tag),
    .ld_valid      (ld_valid),
    .ld_tag        (ld_tag),
    .ld_data       (ld_data),
    .wreg          (wreg),
    .waddr         (waddr),
    .wrdata        (wrdata),
    .busy          (busy),
    .ld_err        (ld_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input logic v, input logic [4:0] rd, input logic is_ld,
                           input logic [31:0] d);
    alloc_valid   = v;
    alloc_rd      = rd;
    alloc_is_load = is_ld;
    alloc_data    = d;
  endtask

  task automatic check_write(input string tag, input logic we, input logic [4:0] a,
                             input logic [31:0] d);
    check({tag, ".wreg"},   {31'd0, wreg}, {31'd0, we});
    check({tag, ".waddr"},  {27'd0, waddr}, {27'd0, a});
    check({tag, ".wrdata"}, wrdata, d);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ld_valid = 1'b0; ld_tag = '0; ld_data = '0;
    set_alloc(1'b0, 5'd0, 1'b0, 32'h0);

    // reset state
    tick(); tick();
    check_write("rst", 1'b0, 5'd0, 32'h0);
    check("rst.busy", busy, 32'h0);
    check("rst.ld_err", {31'd0, ld_err}, 32'h0);
    check("rst.alloc_ready", {31'd0, alloc_ready}, 32'h0);
    rst_n = 1'b1;
    #1;
    check("rel.alloc_ready", {31'd0, alloc_ready}, 32'h1);
    check("rel.wreg", {31'd0, wreg}, 32'h0);

    // ALU rd=5: write appears after the second edge
    set_alloc(1'b1, 5'd5, 1'b0, 32'hDEAD_BEEF);
    check("alu.tag", {30'd0, alloc_tag}, 32'd0);
    tick();
    set_alloc(1'b0, 5'd0, 1'b0, 32'h0);
    check("alu.busy_set", busy, 32'h0000_0020);
    check("alu.wreg_early", {31'd0, wreg}, 32'h0);
    tick();
    check_write("alu.wr", 1'b1, 5'd5, 32'hDEAD_BEEF);
    check("alu.busy_clr", busy, 32'h0);
    tick();
    check_write("alu.idle", 1'b0, 5'd5, 32'hDEAD_BEEF);

    // pending head load blocks the younger ALU entry
    set_alloc(1'b1, 5'd3, 1'b1, 32'h0);
    check("ld.tag", {30'd0, alloc_tag}, 32'd1);
    tick();
    set_alloc(1'b1, 5'd4, 1'b0, 32'h0000_0044);
    tick();
    set_alloc(1'b0, 5'd0, 1'b0, 32'h0);
    check("ld.busy", busy, 32'h0000_0018);
    tick(); tick();
    check("ld.blocked", {31'd0, wreg}, 32'h0);
    ld_valid = 1'b1; ld_tag = 2'd1; ld_data = 32'h0000_1234;
    tick();
    ld_valid = 1'b0;
    check("ld.fill_wreg", {31'd0, wreg}, 32'h0);
    check("ld.fill_err", {31'd0, ld_err}, 32'h0);
    tick();
    check_write("ld.x3", 1'b1, 5'd3, 32'h0000_1234);
    check("ld.busy_x4", busy, 32'h0000_0010);
    tick();
    check_write("ld.x4", 1'b1, 5'd4, 32'h0000_0044);
    check("ld.busy_clr", busy, 32'h0);
    tick();
    check("ld.idle", {31'd0, wreg}, 32'h0);

    // fill all four slots, tail wraps 3->0; alloc held through the full window
    set_alloc(1'b1, 5'd6, 1'b1, 32'h0);
    check("full.tag3", {30'd0, alloc_tag}, 32'd3);
    tick();
    set_alloc(1'b1, 5'd7, 1'b0, 32'h0000_0070);
    check("full.wrap_tag", {30'd0, alloc_tag}, 32'd0);
    tick();
    set_alloc(1'b1, 5'd8, 1'b0, 32'h0000_0080);
    tick();
    set_alloc(1'b1, 5'd9, 1'b0, 32'h0000_0090);
    tick();
    set_alloc(1'b1, 5'd10, 1'b0, 32'h0000_000A);
    check("full.ready", {31'd0, alloc_ready}, 32'h0);
    check("full.tag", {30'd0, alloc_tag}, 32'd3);
    check("full.busy", busy, 32'h0000_03C0);
    ld_valid = 1'b1; ld_tag = 2'd3; ld_data = 32'h0000_0066;
    tick();
    ld_valid = 1'b0;
    check("full.ready_fill", {31'd0, alloc_ready}, 32'h0);
    tick();
    check_write("full.x6", 1'b1, 5'd6, 32'h0000_0066);
    check("full.ready_after", {31'd0, alloc_ready}, 32'h1);
    check("full.tag_after", {30'd0, alloc_tag}, 32'd3);
    tick();
    set_alloc(1'b0, 5'd0, 1'b0, 32'h0);
    check_write("full.x7", 1'b1, 5'd7, 32'h0000_0070);
    check("full.tag_wrap2", {30'd0, alloc_tag}, 32'd0);
    check("full.busy2", busy, 32'h0000_0700);
    tick();
    check_write("full.x8", 1'b1, 5'd8, 32'h0000_0080);
    tick();
    check_write("full.x9", 1'b1, 5'd9, 32'h0000_0090);
    tick();
    check_write("full.x10", 1'b1, 5'd10, 32'h0000_000A);
    tick();
    check("full.idle", {31'd0, wreg}, 32'h0);
    check("full.busy_clr", busy, 32'h0);

    // rd=0 entry retires silently; fill to an empty slot errors
    set_alloc(1'b1, 5'd0, 1'b0, 32'h0000_0055);
    check("x0.tag", {30'd0, alloc_tag}, 32'd0);
    tick();
    set_alloc(1'b0, 5'd0, 1'b0, 32'h0);
    check("x0.busy", busy, 32'h0);
    tick();
    check_write("x0.retire", 1'b0, 5'd0, 32'h0000_0055);
    ld_valid = 1'b1; ld_tag = 2'd2; ld_data = 32'hBAD0_0000;
    tick();
    ld_valid = 1'b0;
    check("empty.ld_err", {31'd0, ld_err}, 32'h1);
    tick();
    check("empty.ld_err_clr", {31'd0, ld_err}, 32'h0);
    check("empty.wreg", {31'd0, wreg}, 32'h0);
    check("empty.busy", busy, 32'h0);
    check("empty.tag", {30'd0, alloc_tag}, 32'd1);

    // flush with two pending loads, concurrent alloc and ld_valid
    set_alloc(1'b1, 5'd1, 1'b1, 32'h0);
    tick();
    set_alloc(1'b1, 5'd2, 1'b1, 32'h0);
    tick();
    check("fl.busy_pre", busy, 32'h0000_0006);
    set_alloc(1'b1, 5'd9, 1'b0, 32'h0000_0099);
    flush = 1'b1; ld_valid = 1'b1; ld_tag = 2'd1; ld_data = 32'h0000_0011;
    #1;
    check("fl.ready", {31'd0, alloc_ready}, 32'h0);
    tick();
    flush = 1'b0; ld_valid = 1'b0;
    set_alloc(1'b0, 5'd0, 1'b0, 32'h0);
    check("fl.busy", busy, 32'h0);
    check("fl.tag", {30'd0, alloc_tag}, 32'd0);
    check("fl.count", {29'd0, dut.count}, 32'd0);
    check("fl.ld_err", {31'd0, ld_err}, 32'h0);
    ld_valid = 1'b1; ld_tag = 2'd1; ld_data = 32'h0000_0077;
    tick();
    ld_valid = 1'b0;
    check("fl.late_err", {31'd0, ld_err}, 32'h1);
    tick();
    check("fl.no_write", {31'd0, wreg}, 32'h0);
    check("fl.busy_late", busy, 32'h0);

    // asynchronous reset with three queued entries
    set_alloc(1'b1, 5'd11, 1'b1, 32'h0);
    tick();
    set_alloc(1'b1, 5'd12, 1'b0, 32'h0000_00C0);
    tick();
    set_alloc(1'b1, 5'd13, 1'b0, 32'h0000_00D0);
    tick();
    set_alloc(1'b0, 5'd0, 1'b0, 32'h0);
    check("mr.busy_pre", busy, 32'h0000_3800);
    rst_n = 1'b0;
    #1;
    check("mr.busy_async", busy, 32'h0);
    check("mr.ready_async", {31'd0, alloc_ready}, 32'h0);
    tick();
    check_write("mr", 1'b0, 5'd0, 32'h0);
    check("mr.busy", busy, 32'h0);
    check("mr.count", {29'd0, dut.count}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("mr.ready_rel", {31'd0, alloc_ready}, 32'h1);
    check("mr.tag_rel", {30'd0, alloc_tag}, 32'd0);
    set_alloc(1'b1, 5'd5, 1'b0, 32'h0000_0505);
    tick();
    set_alloc(1'b0, 5'd0, 1'b0, 32'h0);
    tick();
    check_write("mr.after", 1'b1, 5'd5, 32'h0000_0505);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
